// File: rtl/msk_demux_par.sv
// Masked 1-to-2 demultiplexer: steers a shared bundle into one of two registered output slots.
// Latency: 1 cycle (accept at edge n, out_x_valid from edge n); backpressure: in_ready follows targeted slot.
module msk_demux_par #(
    parameter int d     = 1,
    parameter int count = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [count*d-1:0]   in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [count*d-1:0]   out_t_data,
    output logic                 out_t_valid,
    input  logic                 out_t_ready,
    output logic [count*d-1:0]   out_f_data,
    output logic                 out_f_valid,
    input  logic                 out_f_ready
);

    localparam int W = count * d;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_st_e;

    slot_st_e         t_st_q, f_st_q;
    logic [W-1:0]     t_dat_q, f_dat_q;

    logic t_can_take, f_can_take;
    logic t_drain, f_drain;
    logic acc_t, acc_f;

    // A FULL slot can still take a bundle when its consumer drains it this cycle.
    assign t_can_take = (t_st_q == EMPTY) || out_t_ready;
    assign f_can_take = (f_st_q == EMPTY) || out_f_ready;
    assign t_drain    = (t_st_q == FULL) && out_t_ready;
    assign f_drain    = (f_st_q == FULL) && out_f_ready;

    assign in_ready = in_sel ? t_can_take : f_can_take;
    assign acc_t    = in_valid && in_ready && in_sel;
    assign acc_f    = in_valid && in_ready && !in_sel;

    // in_sel only gates load enables; shares are copied bit-for-bit, never combined.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_st_q  <= EMPTY;
            f_st_q  <= EMPTY;
            t_dat_q <= '0;
            f_dat_q <= '0;
        end else begin
            case (t_st_q)
                EMPTY:   if (acc_t) t_st_q <= FULL;
                FULL:    if (t_drain && !acc_t) t_st_q <= EMPTY;
                default: t_st_q <= EMPTY;
            endcase
            case (f_st_q)
                EMPTY:   if (acc_f) f_st_q <= FULL;
                FULL:    if (f_drain && !acc_f) f_st_q <= EMPTY;
                default: f_st_q <= EMPTY;
            endcase
            if (acc_t) t_dat_q <= in_data;
            if (acc_f) f_dat_q <= in_data;
        end
    end

    assign out_t_valid = (t_st_q == FULL);
    assign out_f_valid = (f_st_q == FULL);
    assign out_t_data  = t_dat_q;
    assign out_f_data  = f_dat_q;

endmodule

// File: doc/msk_demux_par.md
# msk_demux_par

Registered, handshaked 1-to-2 demultiplexer for masked (shared) bundles: routes each `count`-bit value, carried as `d` shares per bit, from one input stream to one of two output streams. It is the fan-out counterpart of the masked parallel 2-to-1 selector in the Clyde datapath, used where a shared state word must be steered to one of two consumers (e.g. S-box layer vs. linear layer). It holds one entry per destination slot. Shares are never recombined or mixed.

## Interface
- `d`, 1: number of shares per bit.
- `count`, 1: number of masked bits per bundle.
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `in_data`  in  count*d  input bundle. Bit i, share j sits at `in_data[i*d+j]`.
- `in_sel`  in  1  destination select: 1 routes to the `t` slot, 0 routes to the `f` slot. Not a secret.
- `in_valid`  in  1  input bundle valid.
- `in_ready`  out  1  input bundle accepted when `in_valid && in_ready`.
- `out_t_data`  out  count*d  `t` slot data, same share layout as `in_data`.
- `out_t_valid`  out  1  `t` slot holds a bundle.
- `out_t_ready`  in  1  `t` consumer accepts.
- `out_f_data`  out  count*d  `f` slot data.
- `out_f_valid`  out  1  `f` slot holds a bundle.
- `out_f_ready`  in  1  `f` consumer accepts.

## Operation
- **Slots and their states.** There are two independent slots, `t` and `f`. Each has a data register (count*d bits) and a 2-state FSM: EMPTY (valid=0) or FULL (valid=1).
- **Slot transitions:**
  - EMPTY → FULL on an accept whose `in_sel` targets this slot.
  - FULL → EMPTY on drain (`out_x_valid && out_x_ready`) with no accept targeting this slot.
  - FULL → FULL on a simultaneous drain and accept to this slot (pass-through refill).
  - FULL holds otherwise.
- **Ready rule.** `in_ready` = targeted slot EMPTY, or targeted slot FULL and being drained this cycle. It is a combinational function of `in_sel`, the slot state and `out_x_ready`. It is independent of `in_valid` and `in_data`.
- **Data load.** A slot's data register loads `in_data` only on an accept targeting that slot. Otherwise it holds its value.
  - The non-targeted register never changes on an accept.
  - The load enable is the only use of `in_sel`. No share of `in_data` is ANDed or combined with any other share or with the other slot.
- **Data visibility.** `out_x_data` is driven directly from the register, so it is glitch-free. It is meaningful only while `out_x_valid` is 1, but the held value remains stable after a drain.
- **Protocol obligations on the upstream:**
  - `in_sel` and `in_data` stay stable while `in_valid && !in_ready`.
  - `in_valid` is not withdrawn before acceptance.
- **Slot independence.** The two slots are fully independent. Accepting into `t` while `f` drains, or both draining together, is legal.
- **Ordering.** Per slot, order is preserved. No ordering is guaranteed between slots.
- **Reset.** `rst` = 1 for one edge forces both slots EMPTY and both data registers to all-zero, which is a valid sharing of 0.
  - Reset takes priority over any accept or drain in the same cycle.
  - Any bundle held or in flight is dropped.

## Timing
- **Reset values:** `out_t_valid`=0, `out_f_valid`=0, `out_t_data`=0, `out_f_data`=0. `in_ready`=1 after reset for either `in_sel`.
- **Latency.** A bundle accepted at edge n appears on `out_x_data` with `out_x_valid`=1 from edge n onward. That is one cycle of register latency, with no combinational path from `in_data` to the outputs.
- **Throughput.** One bundle per cycle per slot when the consumer holds ready high, including the refill-while-draining case.
- **Full slot.** With the targeted slot FULL and its ready=0, `in_ready`=0. Bundles for the other slot are unaffected if that slot can accept.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `in_valid`=1 → both valids 0, both data 0, `in_ready`=1. Repeat with both slots FULL → both are dropped.
- **Single route.** d=2, count=4: send `in_data`=8'hA5, `in_sel`=1, with `out_t_ready`=0.
  - Next cycle: `out_t_valid`=1, `out_t_data`=8'hA5.
  - `out_f_valid`=0 and `out_f_data` unchanged (0).
- **Backpressure.** With `t` FULL and `out_t_ready`=0, present `in_sel`=1, 8'h3C → `in_ready`=0 and `out_t_data` stays 8'hA5.
  - Then switch to `in_sel`=0 after a legal acceptance order → 8'h3C is accepted into `f`.
- **Pass-through refill.** Stream 8'h01..8'h08 to `t` with `out_t_ready`=1 → `in_ready` stays 1 and the consumer sees 01..08, one per cycle, in order.
- **Simultaneous events.** `t` drains while `f` accepts, and `f` drains while `t` is refilled, in the same cycle → both slots update correctly with no lost or duplicated bundle.
- **Reset mid-stream.** Assert `rst` in the middle of the refill stream → valids drop next edge. The first post-reset accept delivers its own value.
